// File: rtl/quadrature_encoder_generator.sv
// Quadrature encoder generator: turns up/down step requests into A/B
// quadrature cycles, one full Gray cycle (four quarters) per step.
// Requests are queued in a signed saturating pending counter.
// Optional feature: define QUAD_GEN_OVF_EN to add a sticky overflow flag
// (o_ovf, cleared by i_ovf_clr) that records dropped requests.
module quadrature_encoder_generator #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned PEND_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
`ifdef QUAD_GEN_OVF_EN
  input  logic              i_ovf_clr,
  output logic              o_ovf,
`endif
  input  logic              i_up,
  input  logic              i_down,
  output logic              o_a,
  output logic              o_b,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

  localparam logic signed [PEND_W+1:0] P_MAX = (PEND_W+2)'((1 <<< (PEND_W - 1)) - 1);
  localparam logic signed [PEND_W+1:0] P_MIN = -P_MAX - (PEND_W+2)'(1);

  logic [0:0]  state;
  logic [1:0]  quarter;
  logic [15:0] dwell_cnt;
  logic        dir_up;

  logic        pend_nz;
  logic        pend_neg;
  logic        at_end;
  logic        start;
  logic        st_dec;
  logic        st_inc;
  logic signed [PEND_W+1:0] p_ext;
  logic signed [PEND_W+1:0] sum;
  logic        sat_hi;
  logic        sat_lo;
  logic [PEND_W-1:0] pend_nxt;

  // A/B pattern for a given direction and quarter; quarter 3 is the trailing 00.
  function automatic logic [1:0] quad_ab(input logic up, input logic [1:0] q);
    logic [1:0] ab;
    case (q)
      2'd0:    ab = up ? 2'b10 : 2'b01;
      2'd1:    ab = 2'b11;
      2'd2:    ab = up ? 2'b01 : 2'b10;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  // Step start decision and saturating pending-count arithmetic.
  always_comb begin
    pend_nz  = |o_pending;
    pend_neg = o_pending[PEND_W-1];
    at_end   = (state == RUN) && (quarter == 2'd3) && (dwell_cnt == DWELL_LAST);
    start    = pend_nz && ((state == IDLE) || at_end);
    st_dec   = start && !pend_neg;
    st_inc   = start && pend_neg;
    p_ext    = {{2{o_pending[PEND_W-1]}}, o_pending};
    sum      = p_ext
             + {{(PEND_W+1){1'b0}}, i_up}
             + {{(PEND_W+1){1'b0}}, st_inc}
             - {{(PEND_W+1){1'b0}}, i_down}
             - {{(PEND_W+1){1'b0}}, st_dec};
    sat_hi   = sum > P_MAX;
    sat_lo   = sum < P_MIN;
    // Only a single unit can overshoot a limit, so clamping equals dropping it.
    if (sat_hi)      pend_nxt = P_MAX[PEND_W-1:0];
    else if (sat_lo) pend_nxt = P_MIN[PEND_W-1:0];
    else             pend_nxt = sum[PEND_W-1:0];
  end

  // Step FSM: quarter sequencing, dwell timing, registered A/B and pending count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      quarter   <= 2'd0;
      dwell_cnt <= '0;
      dir_up    <= 1'b0;
      o_a       <= 1'b0;
      o_b       <= 1'b0;
      o_pending <= '0;
    end else begin
      o_pending <= pend_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            quarter    <= 2'd0;
            dwell_cnt  <= '0;
            dir_up     <= !pend_neg;
            {o_a, o_b} <= quad_ab(!pend_neg, 2'd0);
          end
        end
        default: begin
          if (dwell_cnt != DWELL_LAST) begin
            dwell_cnt <= dwell_cnt + 16'd1;
          end else begin
            dwell_cnt <= '0;
            if (quarter == 2'd3) begin
              if (start) begin
                quarter    <= 2'd0;
                dir_up     <= !pend_neg;
                {o_a, o_b} <= quad_ab(!pend_neg, 2'd0);
              end else begin
                state <= IDLE;
              end
            end else begin
              quarter    <= quarter + 2'd1;
              {o_a, o_b} <= quad_ab(dir_up, quarter + 2'd1);
            end
          end
        end
      endcase
    end
  end

  // Busy spans every cycle spent in RUN, trailing 00 quarter included.
  always_comb begin
    o_busy = (state == RUN);
  end

`ifdef QUAD_GEN_OVF_EN
  // Sticky overflow flag; a new drop wins over a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              o_ovf <= 1'b0;
    else if (sat_hi || sat_lo) o_ovf <= 1'b1;
    else if (i_ovf_clr)        o_ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_quadrature_encoder_generator.sv
// Self-checking bench for quadrature_encoder_generator (default build).
// A step-level reference model predicts A/B, busy and pending every cycle;
// predictions are queued at drive time and compared after the clock edge.
module tb_quadrature_encoder_generator;

  localparam int DW   = 2;
  localparam int PW   = 4;
  localparam int PMAX = (1 << (PW - 1)) - 1;
  localparam int PMIN = -(1 << (PW - 1));
  localparam int LAST = 4 * DW - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_up;
  logic          i_down;
  logic          o_a;
  logic          o_b;
  logic          o_busy;
  logic [PW-1:0] o_pending;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] ab;
    logic       busy;
    int         pend;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic up;
    logic dn;
    int   hold;
    int   exp_pend;
  } vec_t;
  vec_t tbl[6];

  logic [1:0] up_seq [4];
  logic [1:0] dn_seq [4];

  int   m_pend   = 0;
  logic m_busy   = 1'b0;
  int   m_phase  = 0;
  logic m_dir_up = 1'b0;
  int   m_up_starts = 0;
  int   m_dn_starts = 0;

  int dec_up = 0;
  int dec_dn = 0;

  quadrature_encoder_generator #(
    .DWELL_CYCLES(DW),
    .PEND_W(PW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_up(i_up),
    .i_down(i_down),
    .o_a(o_a),
    .o_b(o_b),
    .o_busy(o_busy),
    .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  // Decoder: an A rising edge with B low is an up count, with B high a down count.
  always @(posedge o_a) begin
    if (!o_b) dec_up++;
    else      dec_dn++;
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = 0;
    m_busy  = 1'b0;
    m_phase = 0;
  endtask

  task automatic drive(input logic up, input logic dn);
    exp_t e;
    exp_t g;
    int   nxt;
    logic strt;
    @(negedge clk);
    i_up   = up;
    i_down = dn;
    strt = (m_pend != 0) && (!m_busy || m_phase == LAST);
    nxt  = m_pend + int'(up) - int'(dn);
    if (strt) nxt = nxt - ((m_pend > 0) ? 1 : -1);
    if (nxt > PMAX) nxt = PMAX;
    if (nxt < PMIN) nxt = PMIN;
    if (strt) begin
      m_dir_up = (m_pend > 0);
      m_busy   = 1'b1;
      m_phase  = 0;
      if (m_dir_up) m_up_starts++;
      else          m_dn_starts++;
    end else if (m_busy && m_phase != LAST) begin
      m_phase++;
    end else begin
      m_busy = 1'b0;
    end
    m_pend = nxt;
    e.ab   = !m_busy ? 2'b00 : (m_dir_up ? up_seq[m_phase / DW] : dn_seq[m_phase / DW]);
    e.busy = m_busy;
    e.pend = nxt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("ab",      int'({o_a, o_b}),          int'(g.ab));
    check("busy",    int'(o_busy),              int'(g.busy));
    check("pending", int'($signed(o_pending)),  g.pend);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || m_pend != 0) && n < 300) begin
      drive(1'b0, 1'b0);
      n++;
    end
    if (m_busy || m_pend != 0) check("drain_timeout", n, 0);
    drive(1'b0, 1'b0);
  endtask

  initial begin
    int du;
    int dd;
    int n;
    up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    dn_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    tbl[0] = '{up: 1'b1, dn: 1'b0, hold: 1,  exp_pend: 1};
    tbl[1] = '{up: 1'b0, dn: 1'b1, hold: 1,  exp_pend: -1};
    tbl[2] = '{up: 1'b1, dn: 1'b1, hold: 5,  exp_pend: 0};
    tbl[3] = '{up: 1'b0, dn: 1'b1, hold: 3,  exp_pend: -2};
    tbl[4] = '{up: 1'b1, dn: 1'b0, hold: 10, exp_pend: 7};
    tbl[5] = '{up: 1'b0, dn: 1'b1, hold: 12, exp_pend: -8};

    rst_n  = 1'b0;
    i_up   = 1'b0;
    i_down = 1'b0;
    #1;
    check("rst_ab",      int'({o_a, o_b}),         0);
    check("rst_busy",    int'(o_busy),             0);
    check("rst_pending", int'($signed(o_pending)), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);

    for (int unsigned v = 0; v < 6; v++) begin
      for (int c = 0; c < tbl[v].hold; c++) drive(tbl[v].up, tbl[v].dn);
      check($sformatf("tbl%0d_pend", v), int'($signed(o_pending)), tbl[v].exp_pend);
      drive(1'b0, 1'b0);
      drain();
    end

    // Three spaced down pulses queue back-to-back down steps.
    du = dec_up;
    dd = dec_dn;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drain();
    check("three_down_dn", dec_dn - dd, 3);
    check("three_down_up", dec_up - du, 0);

    // A down request during an up step: up completes, then down follows.
    du = dec_up;
    dd = dec_dn;
    drive(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drain();
    check("up_then_down_up", dec_up - du, 1);
    check("up_then_down_dn", dec_dn - dd, 1);

    // Asynchronous reset while in quarter 11, with a request still queued.
    du = dec_up;
    dd = dec_dn;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    n = 0;
    while (!(o_a && o_b) && n < 20) begin
      drive(1'b0, 1'b0);
      n++;
    end
    check("reach_q11", int'({o_a, o_b}), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ab",      int'({o_a, o_b}),         0);
    check("midrst_busy",    int'(o_busy),             0);
    check("midrst_pending", int'($signed(o_pending)), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0);
    check("midrst_dec_up", dec_up - du, 1);
    check("midrst_dec_dn", dec_dn - dd, 0);

    // After reset release, a fresh request starts a normal step.
    drive(1'b1, 1'b0);
    drain();

    check("dec_up_total", dec_up, m_up_starts);
    check("dec_dn_total", dec_dn, m_dn_starts);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
